// File: rtl/game_timer_gen_if.sv
// game_timer_gen_if
// Bundles the game-FSM controls and the display/expiry outputs of the round timer.
//   game, start, pause       : controls from the game FSM (master drives)
//   sec_ones, sec_tens       : BCD seconds digits
//   min_bcd                  : BCD minute digits, digit k at [4k+3:4k]
//   running, expired         : state levels
//   expire_pulse, tick       : one-cycle event strobes
interface game_timer_gen_if #(
    parameter int unsigned MIN_DIGITS = 1
);
    logic                    game;
    logic                    start;
    logic                    pause;
    logic [3:0]              sec_ones;
    logic [3:0]              sec_tens;
    logic [4*MIN_DIGITS-1:0] min_bcd;
    logic                    running;
    logic                    expired;
    logic                    expire_pulse;
    logic                    tick;

    modport master (
        output game, start, pause,
        input  sec_ones, sec_tens, min_bcd, running, expired, expire_pulse, tick
    );

    modport slave (
        input  game, start, pause,
        output sec_ones, sec_tens, min_bcd, running, expired, expire_pulse, tick
    );
endinterface

// File: rtl/game_timer_gen.sv
// game_timer_gen
// Game-round timer with an internal 1 Hz prescaler producing BCD digits for the
// seven-segment decoders. Counts up from 00:00 to the limit, or down from the
// limit to 00:00, with pause, restart and expiry signalling.
//   Clock : system clock, rising edge
//   reset : synchronous, active-high clear
//   tmr   : game_timer_gen_if.slave (controls in, digits/status out)
module game_timer_gen #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned MIN_DIGITS    = 1,
    parameter int unsigned LIMIT_MIN     = 1,
    parameter int unsigned LIMIT_SEC     = 0,
    parameter bit          COUNT_DOWN    = 1'b0
) (
    input  logic            Clock,
    input  logic            reset,
    game_timer_gen_if.slave tmr
);
    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned MW = 4 * MIN_DIGITS;

    function automatic logic [MW-1:0] min_to_bcd(input int unsigned v);
        logic [MW-1:0] r;
        int unsigned   x;
        r = '0;
        x = v;
        for (int unsigned k = 0; k < MIN_DIGITS; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    localparam logic [MW-1:0] LIM_MINS = min_to_bcd(LIMIT_MIN);
    localparam logic [3:0]    LIM_ONES = 4'(LIMIT_SEC % 10);
    localparam logic [3:0]    LIM_TENS = 4'(LIMIT_SEC / 10);

    // Initial value loaded on start, and the value that ends the round.
    localparam logic [MW+7:0] LIMIT_VAL = {LIM_MINS, LIM_TENS, LIM_ONES};
    localparam logic [MW+7:0] INIT_VAL  = COUNT_DOWN ? LIMIT_VAL : '0;
    localparam logic [MW+7:0] TERM_VAL  = COUNT_DOWN ? '0 : LIMIT_VAL;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [3:0]    ones, ones_nxt;
    logic [3:0]    tens, tens_nxt;
    logic [MW-1:0] mins, mins_nxt;
    logic          run_flag, run_flag_nxt;
    logic          exp_flag, exp_flag_nxt;
    logic          exp_pulse, exp_pulse_nxt;
    logic          tick_flag, tick_flag_nxt;

    // One-second step of the digit chain (carry for up, borrow for down).
    logic [3:0]    step_ones;
    logic [3:0]    step_tens;
    logic [MW-1:0] step_mins;
    logic          carry;

    always_comb begin
        step_ones = ones;
        step_tens = tens;
        step_mins = mins;
        carry     = 1'b0;
        if (!COUNT_DOWN) begin
            if (ones != 4'd9) begin
                step_ones = ones + 4'd1;
            end else begin
                step_ones = '0;
                if (tens != 4'd5) begin
                    step_tens = tens + 4'd1;
                end else begin
                    step_tens = '0;
                    carry     = 1'b1;
                end
            end
            for (int unsigned k = 0; k < MIN_DIGITS; k++) begin
                if (carry) begin
                    if (mins[4*k +: 4] != 4'd9) begin
                        step_mins[4*k +: 4] = mins[4*k +: 4] + 4'd1;
                        carry = 1'b0;
                    end else begin
                        step_mins[4*k +: 4] = '0;
                    end
                end
            end
        end else begin
            if (ones != 4'd0) begin
                step_ones = ones - 4'd1;
            end else begin
                step_ones = 4'd9;
                if (tens != 4'd0) begin
                    step_tens = tens - 4'd1;
                end else begin
                    step_tens = 4'd5;
                    carry     = 1'b1;
                end
            end
            for (int unsigned k = 0; k < MIN_DIGITS; k++) begin
                if (carry) begin
                    if (mins[4*k +: 4] != 4'd0) begin
                        step_mins[4*k +: 4] = mins[4*k +: 4] - 4'd1;
                        carry = 1'b0;
                    end else begin
                        step_mins[4*k +: 4] = 4'd9;
                    end
                end
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        presc_nxt     = presc;
        ones_nxt      = ones;
        tens_nxt      = tens;
        mins_nxt      = mins;
        tick_flag_nxt = 1'b0;
        exp_pulse_nxt = 1'b0;

        if (!tmr.game) begin
            state_nxt = IDLE;
            presc_nxt = '0;
            ones_nxt  = '0;
            tens_nxt  = '0;
            mins_nxt  = '0;
        end else if (tmr.start) begin
            state_nxt                       = RUN;
            presc_nxt                       = '0;
            {mins_nxt, tens_nxt, ones_nxt}  = INIT_VAL;
        end else begin
            case (state)
                // The edge that releases pause already counts, so a pause of
                // N cycles stretches the round by exactly N cycles.
                RUN, PAUSE: begin
                    if (tmr.pause) begin
                        state_nxt = PAUSE;
                    end else begin
                        state_nxt = RUN;
                        if (presc == PRESC_LAST) begin
                            presc_nxt     = '0;
                            ones_nxt      = step_ones;
                            tens_nxt      = step_tens;
                            mins_nxt      = step_mins;
                            tick_flag_nxt = 1'b1;
                            if ({step_mins, step_tens, step_ones} == TERM_VAL) begin
                                state_nxt     = DONE;
                                exp_pulse_nxt = 1'b1;
                            end
                        end else begin
                            presc_nxt = presc + PW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        run_flag_nxt = (state_nxt == RUN);
        exp_flag_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state     <= IDLE;
            presc     <= '0;
            ones      <= '0;
            tens      <= '0;
            mins      <= '0;
            run_flag  <= 1'b0;
            exp_flag  <= 1'b0;
            exp_pulse <= 1'b0;
            tick_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            ones      <= ones_nxt;
            tens      <= tens_nxt;
            mins      <= mins_nxt;
            run_flag  <= run_flag_nxt;
            exp_flag  <= exp_flag_nxt;
            exp_pulse <= exp_pulse_nxt;
            tick_flag <= tick_flag_nxt;
        end
    end

    assign tmr.sec_ones     = ones;
    assign tmr.sec_tens     = tens;
    assign tmr.min_bcd      = mins;
    assign tmr.running      = run_flag;
    assign tmr.expired      = exp_flag;
    assign tmr.expire_pulse = exp_pulse;
    assign tmr.tick         = tick_flag;
endmodule

// File: tb/tb_game_timer_gen.sv
// tb_game_timer_gen
// Three timer instances: up (4 ticks/s, 1:00), down (4 ticks/s, 1:00) and a
// two-minute-digit up counter (2 ticks/s, 10:05). Expected tick events (cycle,
// digits, expiry flag) are queued by the stimulus and consumed by per-instance
// monitors whenever the DUT raises tick or expire_pulse.
module tb_game_timer_gen;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    game_timer_gen_if #(.MIN_DIGITS(1)) up_if ();
    game_timer_gen_if #(.MIN_DIGITS(1)) dn_if ();
    game_timer_gen_if #(.MIN_DIGITS(2)) w_if ();

    game_timer_gen #(.TICKS_PER_SEC(4), .MIN_DIGITS(1), .LIMIT_MIN(1), .LIMIT_SEC(0), .COUNT_DOWN(1'b0))
        u_up (.Clock(clk), .reset(reset), .tmr(up_if));
    game_timer_gen #(.TICKS_PER_SEC(4), .MIN_DIGITS(1), .LIMIT_MIN(1), .LIMIT_SEC(0), .COUNT_DOWN(1'b1))
        u_dn (.Clock(clk), .reset(reset), .tmr(dn_if));
    game_timer_gen #(.TICKS_PER_SEC(2), .MIN_DIGITS(2), .LIMIT_MIN(10), .LIMIT_SEC(5), .COUNT_DOWN(1'b0))
        u_w (.Clock(clk), .reset(reset), .tmr(w_if));

    typedef struct {
        int unsigned cyc;
        logic [15:0] dig;
        logic        last;
    } item_t;

    item_t q_up[$];
    item_t q_dn[$];
    item_t q_w[$];
    item_t it_up, it_dn, it_w;

    int unsigned cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int unsigned t0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] up_dig, dn_dig, w_dig;
    assign up_dig = {4'h0, up_if.min_bcd, up_if.sec_tens, up_if.sec_ones};
    assign dn_dig = {4'h0, dn_if.min_bcd, dn_if.sec_tens, dn_if.sec_ones};
    assign w_dig  = {w_if.min_bcd, w_if.sec_tens, w_if.sec_ones};

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    function automatic void spurious(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event at cycle %0d, required none", name, cyc);
    endfunction

    // Elapsed seconds as BCD {min tens, min ones, sec tens, sec ones}.
    function automatic logic [15:0] bcd_time(input int unsigned s);
        int unsigned m, r;
        m = s / 60;
        r = s % 60;
        return {4'((m / 10) % 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    always @(negedge clk) begin
        if (up_if.tick || up_if.expire_pulse) begin
            if (q_up.size() == 0) spurious("up_tick");
            else begin
                it_up = q_up.pop_front();
                chk("up_tick", {cyc, up_dig, up_if.tick, up_if.expire_pulse},
                    {it_up.cyc, it_up.dig, 1'b1, it_up.last});
            end
        end
    end

    always @(negedge clk) begin
        if (dn_if.tick || dn_if.expire_pulse) begin
            if (q_dn.size() == 0) spurious("dn_tick");
            else begin
                it_dn = q_dn.pop_front();
                chk("dn_tick", {cyc, dn_dig, dn_if.tick, dn_if.expire_pulse},
                    {it_dn.cyc, it_dn.dig, 1'b1, it_dn.last});
            end
        end
    end

    always @(negedge clk) begin
        if (w_if.tick || w_if.expire_pulse) begin
            if (q_w.size() == 0) spurious("w_tick");
            else begin
                it_w = q_w.pop_front();
                chk("w_tick", {cyc, w_dig, w_if.tick, w_if.expire_pulse},
                    {it_w.cyc, it_w.dig, 1'b1, it_w.last});
            end
        end
    end

    initial begin
        reset = 1'b1;
        up_if.game = 1'b1; up_if.start = 1'b0; up_if.pause = 1'b0;
        dn_if.game = 1'b1; dn_if.start = 1'b0; dn_if.pause = 1'b0;
        w_if.game  = 1'b1; w_if.start  = 1'b0; w_if.pause  = 1'b0;
        repeat (3) @(negedge clk);
        chk("up_reset", {up_dig, up_if.running, up_if.expired, up_if.expire_pulse, up_if.tick}, 64'h0);
        chk("dn_reset", {dn_dig, dn_if.running, dn_if.expired, dn_if.expire_pulse, dn_if.tick}, 64'h0);
        chk("w_reset",  {w_dig, w_if.running, w_if.expired, w_if.expire_pulse, w_if.tick}, 64'h0);
        reset = 1'b0;

        // ---------------- up count to 1:00 ----------------
        up_if.start = 1'b1;
        @(negedge clk);
        up_if.start = 1'b0;
        t0 = cyc;
        chk("up_load", {up_dig, up_if.running, up_if.expired}, {16'h0000, 1'b1, 1'b0});
        for (int k = 1; k <= 60; k++)
            q_up.push_back('{cyc: t0 + 4*k, dig: bcd_time(k), last: (k == 60)});
        repeat (240) @(negedge clk);
        chk("up_expired", {up_dig, up_if.running, up_if.expired}, {16'h0100, 1'b0, 1'b1});
        repeat (5) @(negedge clk);
        chk("up_hold", {up_dig, up_if.running, up_if.expired}, {16'h0100, 1'b0, 1'b1});

        // restart from DONE
        up_if.start = 1'b1;
        @(negedge clk);
        up_if.start = 1'b0;
        t0 = cyc;
        chk("up_restart_done", {up_dig, up_if.running, up_if.expired}, {16'h0000, 1'b1, 1'b0});
        for (int k = 1; k <= 7; k++)
            q_up.push_back('{cyc: t0 + 4*k, dig: bcd_time(k), last: 1'b0});
        repeat (28) @(negedge clk);
        chk("up_at_0_07", up_dig, 16'h0007);

        // restart while running
        up_if.start = 1'b1;
        @(negedge clk);
        up_if.start = 1'b0;
        t0 = cyc;
        chk("up_restart_run", {up_dig, up_if.tick, up_if.running}, {16'h0000, 1'b0, 1'b1});
        q_up.push_back('{cyc: t0 + 4, dig: bcd_time(1), last: 1'b0});
        q_up.push_back('{cyc: t0 + 8, dig: bcd_time(2), last: 1'b0});
        repeat (11) @(negedge clk);

        // start coincides with a step edge
        up_if.start = 1'b1;
        @(negedge clk);
        up_if.start = 1'b0;
        chk("up_start_on_step", {up_dig, up_if.tick, up_if.running}, {16'h0000, 1'b0, 1'b1});

        // start together with pause
        up_if.start = 1'b1;
        up_if.pause = 1'b1;
        @(negedge clk);
        up_if.start = 1'b0;
        up_if.pause = 1'b0;
        t0 = cyc;
        chk("up_start_over_pause", {up_dig, up_if.running}, {16'h0000, 1'b1});
        q_up.push_back('{cyc: t0 + 4,  dig: bcd_time(1), last: 1'b0});
        q_up.push_back('{cyc: t0 + 18, dig: bcd_time(2), last: 1'b0});
        q_up.push_back('{cyc: t0 + 22, dig: bcd_time(3), last: 1'b0});

        // 10-cycle pause starting 2 cycles after a tick
        repeat (6) @(negedge clk);
        up_if.pause = 1'b1;
        repeat (10) @(negedge clk);
        chk("up_paused", {up_dig, up_if.running}, {16'h0001, 1'b0});
        up_if.pause = 1'b0;
        repeat (7) @(negedge clk);

        // game low mid-round
        up_if.game = 1'b0;
        @(negedge clk);
        chk("up_game_clear", {up_dig, up_if.running, up_if.expired, up_if.expire_pulse, up_if.tick}, 64'h0);
        up_if.game = 1'b1;
        repeat (8) @(negedge clk);
        chk("up_idle", {up_dig, up_if.running}, 64'h0);

        // ---------------- down count from 1:00 ----------------
        dn_if.start = 1'b1;
        @(negedge clk);
        dn_if.start = 1'b0;
        t0 = cyc;
        chk("dn_load", {dn_dig, dn_if.running}, {16'h0100, 1'b1});
        for (int k = 1; k <= 60; k++)
            q_dn.push_back('{cyc: t0 + 4*k, dig: bcd_time(60 - k), last: (k == 60)});
        repeat (240) @(negedge clk);
        chk("dn_expired", {dn_dig, dn_if.running, dn_if.expired}, {16'h0000, 1'b0, 1'b1});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("dn_reset_done", {dn_dig, dn_if.running, dn_if.expired, dn_if.expire_pulse, dn_if.tick}, 64'h0);

        // ---------------- two minute digits, 10:05 ----------------
        w_if.start = 1'b1;
        @(negedge clk);
        w_if.start = 1'b0;
        t0 = cyc;
        for (int k = 1; k <= 605; k++)
            q_w.push_back('{cyc: t0 + 2*k, dig: bcd_time(k), last: (k == 605)});
        repeat (1210) @(negedge clk);
        chk("w_expired", {w_dig, w_if.running, w_if.expired}, {16'h1005, 1'b0, 1'b1});

        repeat (3) @(negedge clk);
        chk("up_queue_drained", 64'(q_up.size()), 64'h0);
        chk("dn_queue_drained", 64'(q_dn.size()), 64'h0);
        chk("w_queue_drained",  64'(q_w.size()),  64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/game_timer_gen.md
# game_timer_gen

Parametrised game-round timer that produces BCD digits (seconds ones, seconds tens, N minute digits) for the seven-segment decoders. It has an internal 1 Hz prescaler, count-up or count-down mode, a configurable round length, pause, restart and expiry signalling. It sits between the game FSM (game, start, pause) and the hex display decoders, and its expiry outputs feed back to the FSM.

## Interface
- TICKS_PER_SEC, 50_000_000: Clock cycles per displayed second; must be ≥ 2.
- MIN_DIGITS, 1: number of BCD minute digits; 1..3.
- LIMIT_MIN, 1: round-length minutes; 0..10^MIN_DIGITS−1.
- LIMIT_SEC, 0: round-length seconds; 0..59. Total limit must be ≥ 1 s.
- COUNT_DOWN, 0: 0 = count up from 00:00 to limit; 1 = count down from limit to 00:00.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- game  in  1  level; low forces the same clear as reset.
- start  in  1  pulse; starts or restarts a round.
- pause  in  1  level; freezes the count while high.
- sec_ones  out  4  BCD 0..9.
- sec_tens  out  4  BCD 0..5.
- min_bcd  out  4*MIN_DIGITS  BCD minutes; digit k is at bits [4k+3:4k].
- running  out  1  high in RUN.
- expired  out  1  level, high in DONE.
- expire_pulse  out  1  one-cycle pulse on entry to DONE.
- tick  out  1  one-cycle pulse each time the digits change.

## Operation
- Registered FSM with states IDLE, RUN, PAUSE, DONE.
- Reset value of every output is 0: digits 00:00, running, expired, expire_pulse and tick. State = IDLE, prescaler = 0.
- Input priority per cycle: reset > ~game > start > pause.
- IDLE: digits 0. If start=1 → RUN. On that edge digits load the initial value (00:00 for up, LIMIT for down) and the prescaler clears.
- RUN:
  - Prescaler increments each cycle. At TICKS_PER_SEC−1 it wraps to 0 and the digits step by one second.
  - Up mode: sec_ones 9→0 carries to sec_tens; sec_tens 5→0 carries to min digit 0; each minute digit 9→0 carries to the next.
  - Down mode: mirrored borrows (0→9, 0→5).
  - pause=1 → PAUSE.
- PAUSE: prescaler and digits hold. pause=0 → RUN, and the prescaler resumes from its held value (no lost partial second).
- Terminal value: up mode = LIMIT, down mode = 00:00. On the edge where the digits step to the terminal value, state → DONE, expired=1 and expire_pulse=1 for one cycle. Digits hold the terminal value.
- DONE: digits held, running=0. start=1 → restart exactly as from IDLE; expired clears on the same edge.
- start while in RUN or PAUSE: full restart (reload initial value, prescaler 0, stay in or return to RUN). start takes priority over pause on that edge.
- game=0 or reset=1 in any state, including mid-second or in DONE: everything clears to reset values next edge. Any expire_pulse not yet issued is lost.
- A step and a start on the same edge: start wins, and no tick is issued.
- Digits never leave BCD range, never pass LIMIT (up) and never underflow (down).

## Timing
- All outputs registered.
- tick is high in the same cycle the new digit values first appear.
- The first digit step is exactly TICKS_PER_SEC cycles after the start edge. Subsequent steps follow every TICKS_PER_SEC cycles of RUN time.
- expire_pulse coincides with the final tick, in the same cycle.
- running falls and expired rises in that same cycle.
- Round length = (LIMIT_MIN*60 + LIMIT_SEC) * TICKS_PER_SEC RUN cycles, measured start edge to expire edge.
- Paused cycles add exactly their own count to the round length.

## Test plan
- Up count (TICKS=4, MIN_DIGITS=1, LIMIT 1:00, up): start, then 240 cycles. Required: ticks every 4 cycles, 0:09→0:10 and 0:59→1:00 carries, expire_pulse on cycle 240, digits hold 1:00, expired=1.
- Down count (same config, COUNT_DOWN=1): start → 1:00 shown. After 4 cycles shows 0:59; borrow 0:10→0:09 is correct. Expiry at 0:00 after 240 cycles.
- Pause (TICKS=4, up): pause for 10 cycles mid-second, starting 2 cycles after a tick. Required: digits and prescaler frozen, next tick exactly 2 cycles after pause falls, no extra tick.
- Restart and priority: start in RUN at 0:07 → 0:00, next tick 4 cycles later. start together with pause=1 → RUN. start on a step edge → 0:00 with tick=0.
- Clears: game=0 mid-round → next cycle all outputs 0, state IDLE. reset=1 in DONE → expired=0. start in DONE → new round, expired drops on the start edge.
- Width (MIN_DIGITS=2, LIMIT 10:05, TICKS=2, up): min_bcd 0x09→0x10 carry, expiry at min_bcd=0x10, sec_tens=0, sec_ones=5.
